// File: rtl/clock_pkg.sv
// Shared hours-path types and BCD constants for the time-set and display logic.
package clock_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_CONVERT,
      ST_LOAD
   } hs_state_e;

   localparam logic [7:0] HOURS_MAX_24    = 8'h23;
   localparam logic [7:0] HOURS_MAX_12    = 8'h12;
   localparam logic [7:0] HOURS_PM_OFFSET = 8'h12;

endpackage

// File: rtl/hours_to_24h_conv.sv
// Combinational check and conversion of a display-format BCD hour (12h+PM or 24h) to 24-hour BCD.
module hours_to_24h_conv
   import clock_pkg::*;
(
   input  logic [3:0] msd_i,
   input  logic [3:0] lsd_i,
   input  logic       pm_i,
   input  logic       military_i,
   output logic       valid_o,
   output logic [3:0] msd_o,
   output logic [3:0] lsd_o
);

   logic       valid24;
   logic       valid12;
   logic       is_twelve;
   logic [4:0] lsd_sum;
   logic [4:0] lsd_wrap;

   always_comb begin
      valid24   = (msd_i < 4'd2) ? (lsd_i <= 4'd9) : ((msd_i == 4'd2) && (lsd_i <= 4'd3));
      valid12   = ((msd_i == 4'd0) && (lsd_i != 4'd0) && (lsd_i <= 4'd9)) ||
                  ((msd_i == 4'd1) && (lsd_i <= 4'd2));
      is_twelve = ({msd_i, lsd_i} == HOURS_MAX_12);
      lsd_sum   = {1'b0, lsd_i} + {1'b0, HOURS_PM_OFFSET[3:0]};
      lsd_wrap  = lsd_sum - 5'd10;
      valid_o   = 1'b0;
      msd_o     = msd_i;
      lsd_o     = lsd_i;
      if (military_i) begin
         valid_o = valid24;
      end else begin
         valid_o = valid12;
         if (is_twelve) begin
            // 12 AM is midnight; 12 PM is noon and passes through
            if (!pm_i) begin
               msd_o = 4'd0;
               lsd_o = 4'd0;
            end
         end else if (pm_i) begin
            if (lsd_sum > 5'd9) begin
               lsd_o = lsd_wrap[3:0];
               msd_o = msd_i + HOURS_PM_OFFSET[7:4] + 4'd1;
            end else begin
               lsd_o = lsd_sum[3:0];
               msd_o = msd_i + HOURS_PM_OFFSET[7:4];
            end
         end
      end
   end

endmodule

// File: rtl/hours_set_decoder.sv
// Validates a user hours request, converts it to 24h BCD and hands it to the hours register.
// Build option HOURS_SET_CLAMP_EN: clamp invalid requests (with err) instead of rejecting them.
module hours_set_decoder
   import clock_pkg::*;
#(
   parameter int LOAD_TIMEOUT = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       military_time,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_msd,
   input  logic [3:0] req_lsd,
   input  logic       req_pm,
   output logic       load_valid,
   input  logic       load_ready,
   output logic [3:0] load_msd,
   output logic [3:0] load_lsd,
   output logic       err,
   output logic       busy
);

   localparam bit         TMO_EN   = (LOAD_TIMEOUT != 0);
   localparam logic [7:0] TMO_LAST = 8'(LOAD_TIMEOUT - 1);

   hs_state_e  state_q;
   logic       mil_q;
   logic       pm_q;
   logic [3:0] msd_q;
   logic [3:0] lsd_q;
   logic       req_ready_q;
   logic       busy_q;
   logic       load_valid_q;
   logic [3:0] load_msd_q;
   logic [3:0] load_lsd_q;
   logic       err_q;
   logic [7:0] tmo_q;

   logic       conv_valid;
   logic [3:0] conv_msd;
   logic [3:0] conv_lsd;

   hours_to_24h_conv u_conv (
      .msd_i      (msd_q),
      .lsd_i      (lsd_q),
      .pm_i       (pm_q),
      .military_i (mil_q),
      .valid_o    (conv_valid),
      .msd_o      (conv_msd),
      .lsd_o      (conv_lsd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         mil_q        <= 1'b0;
         pm_q         <= 1'b0;
         msd_q        <= 4'd0;
         lsd_q        <= 4'd0;
         req_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         load_valid_q <= 1'b0;
         load_msd_q   <= 4'd0;
         load_lsd_q   <= 4'd0;
         err_q        <= 1'b0;
         tmo_q        <= 8'd0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (req_valid && req_ready_q) begin
                  mil_q       <= military_time;
                  pm_q        <= req_pm;
                  msd_q       <= req_msd;
                  lsd_q       <= req_lsd;
                  err_q       <= 1'b0;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (conv_valid) begin
                  state_q <= ST_CONVERT;
               end else begin
                  err_q <= 1'b1;
`ifdef HOURS_SET_CLAMP_EN
                  // Clamped 12h value keeps the captured PM flag for conversion
                  {msd_q, lsd_q} <= mil_q ? HOURS_MAX_24 : HOURS_MAX_12;
                  state_q        <= ST_CONVERT;
`else
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
`endif
               end
            end
            ST_CONVERT: begin
               load_msd_q   <= conv_msd;
               load_lsd_q   <= conv_lsd;
               load_valid_q <= 1'b1;
               tmo_q        <= 8'd0;
               state_q      <= ST_LOAD;
            end
            ST_LOAD: begin
               if (load_ready) begin
                  load_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= ST_IDLE;
               end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                  err_q        <= 1'b1;
                  load_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= ST_IDLE;
               end else begin
                  tmo_q <= tmo_q + 8'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign busy       = busy_q;
   assign load_valid = load_valid_q;
   assign load_msd   = load_msd_q;
   assign load_lsd   = load_lsd_q;
   assign err        = err_q;

endmodule

// File: tb/tb_hours_set_decoder.sv
// Self-checking bench for hours_set_decoder: vector table, random requests vs. arithmetic model, corner sequences.
module tb_hours_set_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       military_time = 1'b0;
   logic       req_valid = 1'b0;
   logic [3:0] req_msd = 4'd0;
   logic [3:0] req_lsd = 4'd0;
   logic       req_pm = 1'b0;
   logic       load_ready = 1'b1;
   logic       req_ready, load_valid, err, busy;
   logic [3:0] load_msd, load_lsd;

   logic       t_mil = 1'b0;
   logic       t_req_valid = 1'b0;
   logic [3:0] t_msd = 4'd0;
   logic [3:0] t_lsd = 4'd0;
   logic       t_pm = 1'b0;
   logic       t_load_ready = 1'b0;
   logic       t_req_ready, t_load_valid, t_err, t_busy;
   logic [3:0] t_load_msd, t_load_lsd;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hours_set_decoder u_dut (
      .clk(clk), .rst_n(rst_n), .military_time(military_time),
      .req_valid(req_valid), .req_ready(req_ready), .req_msd(req_msd), .req_lsd(req_lsd),
      .req_pm(req_pm), .load_valid(load_valid), .load_ready(load_ready),
      .load_msd(load_msd), .load_lsd(load_lsd), .err(err), .busy(busy)
   );

   hours_set_decoder #(.LOAD_TIMEOUT(4)) u_dut_tmo (
      .clk(clk), .rst_n(rst_n), .military_time(t_mil),
      .req_valid(t_req_valid), .req_ready(t_req_ready), .req_msd(t_msd), .req_lsd(t_lsd),
      .req_pm(t_pm), .load_valid(t_load_valid), .load_ready(t_load_ready),
      .load_msd(t_load_msd), .load_lsd(t_load_lsd), .err(t_err), .busy(t_busy)
   );

   typedef struct {
      logic       mil;
      logic [3:0] msd;
      logic [3:0] lsd;
      logic       pm;
      logic       ld;
      logic [3:0] em;
      logic [3:0] el;
      logic       ee;
   } vec_t;

   vec_t tbl[14];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Reference: whole-number hour arithmetic, independent of digit-level rules
   task automatic model(input logic mil, input int msd, input int lsd, input logic pm,
                        output logic ld, output logic [3:0] om, output logic [3:0] ol,
                        output logic oe);
      int  h;
      logic ok;
      h = msd * 10 + lsd;
      if (mil) ok = (lsd <= 9) && (h <= 23);
      else     ok = (lsd <= 9) && (h >= 1) && (h <= 12);
      ld = ok;
      oe = !ok;
`ifdef HOURS_SET_CLAMP_EN
      if (!ok) begin
         ld = 1'b1;
         h  = mil ? 23 : 12;
      end
`endif
      if (!mil) h = (h % 12) + (pm ? 12 : 0);
      om = 4'(h / 10);
      ol = 4'(h % 10);
   endtask

   task automatic wait_idle(input string tag);
      for (int w = 0; w < 20 && !req_ready; w++) tick();
      chk({tag, "_idle_wait"}, req_ready, 1);
   endtask

   task automatic accept(input logic mil, input logic [3:0] msd, input logic [3:0] lsd,
                         input logic pm);
      military_time = mil;
      req_msd       = msd;
      req_lsd       = lsd;
      req_pm        = pm;
      req_valid     = 1'b1;
      tick();
      req_valid     = 1'b0;
      // Scramble inputs while the request is in flight
      military_time = 1'($urandom);
      req_msd       = 4'($urandom);
      req_lsd       = 4'($urandom);
      req_pm        = 1'($urandom);
   endtask

   task automatic run_req(input string tag, input logic mil, input logic [3:0] msd,
                          input logic [3:0] lsd, input logic pm, input logic ld,
                          input logic [3:0] em, input logic [3:0] el, input logic ee);
      int k;
      wait_idle(tag);
      accept(mil, msd, lsd, pm);
      chk({tag, "_err_clr"}, err, 0);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_rdy_low"}, req_ready, 0);
      if (ld) begin
         k = 0;
         while (!load_valid && k < 10) begin
            tick();
            k++;
         end
         chk({tag, "_latency"}, k, 2);
         chk({tag, "_msd"}, load_msd, em);
         chk({tag, "_lsd"}, load_lsd, el);
         chk({tag, "_err"}, err, ee);
         tick();
         chk({tag, "_vld_drop"}, load_valid, 0);
         chk({tag, "_rdy_back"}, req_ready, 1);
      end else begin
         tick();
         chk({tag, "_rej_rdy"}, req_ready, 1);
         chk({tag, "_rej_err"}, err, 1);
         chk({tag, "_rej_vld"}, load_valid, 0);
         tick();
         tick();
         chk({tag, "_rej_novld"}, load_valid, 0);
         chk({tag, "_err_sticky"}, err, 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic       ld, oe;
      logic [3:0] om, ol;
      logic       mil, pm;
      logic [3:0] msd, lsd;
      int         k;

      tbl[0]  = '{1'b0, 4'd1, 4'd2, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0};
      tbl[1]  = '{1'b0, 4'd1, 4'd1, 1'b1, 1'b1, 4'd2, 4'd3, 1'b0};
      tbl[2]  = '{1'b0, 4'd0, 4'd8, 1'b1, 1'b1, 4'd2, 4'd0, 1'b0};
      tbl[3]  = '{1'b0, 4'd1, 4'd2, 1'b1, 1'b1, 4'd1, 4'd2, 1'b0};
      tbl[4]  = '{1'b0, 4'd0, 4'd7, 1'b0, 1'b1, 4'd0, 4'd7, 1'b0};
      tbl[5]  = '{1'b0, 4'd0, 4'd1, 1'b1, 1'b1, 4'd1, 4'd3, 1'b0};
      tbl[6]  = '{1'b0, 4'd1, 4'd0, 1'b1, 1'b1, 4'd2, 4'd2, 1'b0};
      tbl[7]  = '{1'b1, 4'd2, 4'd3, 1'b0, 1'b1, 4'd2, 4'd3, 1'b0};
      tbl[8]  = '{1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0};
      tbl[9]  = '{1'b1, 4'd1, 4'd9, 1'b0, 1'b1, 4'd1, 4'd9, 1'b0};
`ifdef HOURS_SET_CLAMP_EN
      tbl[10] = '{1'b1, 4'd2, 4'd4, 1'b0, 1'b1, 4'd2, 4'd3, 1'b1};
      tbl[11] = '{1'b0, 4'd1, 4'd3, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1};
      tbl[12] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd1, 4'd2, 1'b1};
      tbl[13] = '{1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 4'd2, 4'd3, 1'b1};
`else
      tbl[10] = '{1'b1, 4'd2, 4'd4, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1};
      tbl[11] = '{1'b0, 4'd1, 4'd3, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1};
      tbl[12] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1};
      tbl[13] = '{1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1};
`endif

      #12;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_load_valid", load_valid, 0);
      chk("rst_msd", load_msd, 0);
      chk("rst_lsd", load_lsd, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      tick();
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 14; i++)
         run_req($sformatf("vec%0d", i), tbl[i].mil, tbl[i].msd, tbl[i].lsd, tbl[i].pm,
                 tbl[i].ld, tbl[i].em, tbl[i].el, tbl[i].ee);

      for (int i = 0; i < 80; i++) begin
         mil = 1'($urandom);
         pm  = 1'($urandom);
         msd = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
         lsd = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 9));
         model(mil, int'(msd), int'(lsd), pm, ld, om, ol, oe);
         run_req($sformatf("rnd%0d", i), mil, msd, lsd, pm, ld, om, ol, oe);
      end

      // Stall in LOAD: outputs hold, new requests ignored and not queued
      wait_idle("stall");
      load_ready = 1'b0;
      accept(1'b1, 4'd1, 4'd5, 1'b0);
      tick();
      tick();
      chk("stall_vld_rise", load_valid, 1);
      for (int i = 0; i < 10; i++) begin
         req_valid = i[0];
         req_msd   = 4'($urandom_range(0, 2));
         req_lsd   = 4'($urandom_range(0, 9));
         tick();
         chk($sformatf("stall_vld%0d", i), load_valid, 1);
         chk($sformatf("stall_msd%0d", i), load_msd, 1);
         chk($sformatf("stall_lsd%0d", i), load_lsd, 5);
         chk($sformatf("stall_rdy%0d", i), req_ready, 0);
      end
      req_valid  = 1'b0;
      load_ready = 1'b1;
      tick();
      chk("stall_done_vld", load_valid, 0);
      chk("stall_done_rdy", req_ready, 1);
      tick();
      tick();
      chk("stall_not_queued", busy, 0);
      chk("stall_no_reload", load_valid, 0);

      // Asynchronous reset while waiting in LOAD
      wait_idle("arst");
      load_ready = 1'b0;
      accept(1'b0, 4'd1, 4'd1, 1'b1);
      tick();
      tick();
      chk("arst_in_load", load_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_rdy", req_ready, 1);
      chk("arst_vld", load_valid, 0);
      chk("arst_msd", load_msd, 0);
      chk("arst_lsd", load_lsd, 0);
      chk("arst_err", err, 0);
      chk("arst_busy", busy, 0);
      tick();
      rst_n      = 1'b1;
      load_ready = 1'b1;
      tick();
      run_req("post_arst", 1'b0, 4'd0, 4'd9, 1'b1, 1'b1, 4'd2, 4'd1, 1'b0);

      // Timeout instance: load_valid for exactly four cycles, then err and IDLE
      t_mil       = 1'b0;
      t_msd       = 4'd0;
      t_lsd       = 4'd7;
      t_pm        = 1'b0;
      t_req_valid = 1'b1;
      tick();
      t_req_valid = 1'b0;
      for (k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("tmo_vld_k%0d", k), t_load_valid, (k >= 2 && k <= 5) ? 1 : 0);
         if (k == 2) begin
            chk("tmo_msd", t_load_msd, 0);
            chk("tmo_lsd", t_load_lsd, 7);
            chk("tmo_err_early", t_err, 0);
         end
         if (k == 6) begin
            chk("tmo_err", t_err, 1);
            chk("tmo_rdy", t_req_ready, 1);
            chk("tmo_busy", t_busy, 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
